// File: rtl/frame_strobe_sequencer.sv
// Column frame writer: takes header/data word pairs on a valid/ready stream,
// drives FrameData, then pulses one FrameStrobe line with setup/hold margin.
// Ports: UserCLK, resetn (sync, active-low); s_data/s_valid/s_ready stream;
//   err_clr clears sticky err; FrameData, FrameStrobe (one-hot) column buses;
//   busy (not idle), frames_done (completed writes, wraps at 256).
module frame_strobe_sequencer #(
  parameter int         FrameBitsPerRow = 32,
  parameter int         MaxFramesPerCol = 20,
  parameter int         StrobeCycles    = 2,
  parameter logic [7:0] SyncByte        = 8'hFA
) (
  input  logic                       UserCLK,
  input  logic                       resetn,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       err_clr,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err,
  output logic [7:0]                 frames_done
);

  localparam int IW =
    (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam logic [7:0] NumFrames  = 8'(MaxFramesPerCol);
  localparam logic [3:0] StrobeLast = 4'(StrobeCycles - 1);
  localparam logic [MaxFramesPerCol-1:0] OneHot0 =
    MaxFramesPerCol'(1);

  typedef enum logic [2:0] {
    IDLE, DATA, SETUP, STROBE, HOLD
  } state_e;

  state_e                     state_q, state_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic [IW-1:0]              index_q, index_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic [7:0]                 done_q, done_d;
  logic                       xfer;
  logic                       hdr_ok;
  logic                       bad_hdr;

  assign s_ready = (state_q == IDLE) || (state_q == DATA);
  assign xfer    = s_valid && s_ready;
  assign hdr_ok  = (s_data[15:8] == SyncByte) &&
                   (s_data[7:0] < NumFrames);

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    strobe_d = strobe_q;
    index_d  = index_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    done_d   = done_q;
    bad_hdr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_ok) begin
            index_d = s_data[IW-1:0];
            state_d = DATA;
          end else begin
            bad_hdr = 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          data_d  = s_data;
          // two settle cycles: strobe rises two edges after data lands
          cnt_d   = 4'd1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          strobe_d = OneHot0 << index_q;
          cnt_d    = StrobeLast;
          state_d  = STROBE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          strobe_d = '0;
          state_d  = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        done_d  = done_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a fresh error outranks a simultaneous clear
    if (err_clr) err_d = 1'b0;
    if (bad_hdr) err_d = 1'b1;
  end

  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q  <= IDLE;
      data_q   <= '0;
      strobe_q <= '0;
      index_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      index_q  <= index_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign FrameData   = data_q;
  assign FrameStrobe = strobe_q;
  assign busy        = (state_q != IDLE);
  assign err         = err_q;
  assign frames_done = done_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// Scoreboard bench: three sequencers (strobe widths 2, 1, 4) share one
// stream; a negedge monitor checks each strobe against queued frames.
module tb_frame_strobe_sequencer;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          e1;
  } exp_t;

  logic        clk = 0;
  logic        resetn = 0;
  logic [31:0] s_data = '0;
  logic        s_valid = 0;
  logic        err_clr = 0;

  logic        rdy    [3];
  logic [31:0] fd     [3];
  logic [19:0] fs     [3];
  logic        busy_w [3];
  logic        err_w  [3];
  logic [7:0]  fdn    [3];

  int   scw [3] = '{2, 1, 4};
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rst_edge = 0;
  bit   err_m = 0;
  int   goods = 0;

  exp_t expq [$];
  int   rd   [3] = '{0, 0, 0};
  bit   act  [3] = '{0, 0, 0};
  int   wid  [3] = '{0, 0, 0};
  int   pend [3] = '{-1, -1, -1};
  int   dmod [3] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_edge <= !resetn;

  frame_strobe_sequencer #(.StrobeCycles(2)) u0 (
    .UserCLK(clk), .resetn(resetn), .s_data(s_data),
    .s_valid(s_valid), .s_ready(rdy[0]), .err_clr(err_clr),
    .FrameData(fd[0]), .FrameStrobe(fs[0]), .busy(busy_w[0]),
    .err(err_w[0]), .frames_done(fdn[0]));

  frame_strobe_sequencer #(.StrobeCycles(1)) u1 (
    .UserCLK(clk), .resetn(resetn), .s_data(s_data),
    .s_valid(s_valid), .s_ready(rdy[1]), .err_clr(err_clr),
    .FrameData(fd[1]), .FrameStrobe(fs[1]), .busy(busy_w[1]),
    .err(err_w[1]), .frames_done(fdn[1]));

  frame_strobe_sequencer #(.StrobeCycles(4)) u2 (
    .UserCLK(clk), .resetn(resetn), .s_data(s_data),
    .s_valid(s_valid), .s_ready(rdy[2]), .err_clr(err_clr),
    .FrameData(fd[2]), .FrameStrobe(fs[2]), .busy(busy_w[2]),
    .err(err_w[2]), .frames_done(fdn[2]));

  wire allrdy = rdy[0] & rdy[1] & rdy[2];
  wire allidle = !busy_w[0] & !busy_w[1] & !busy_w[2];

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h at cycle %0d",
               nm, a, e, cyc);
    end
  endtask

  // monitor: compares each DUT's strobe activity with queued frames
  always @(negedge clk) begin
    if (rst_edge) begin
      for (int i = 0; i < 3; i++) begin
        act[i] = 0; wid[i] = 0; pend[i] = -1; dmod[i] = 0;
        rd[i] = expq.size();
        chk("rst_strobe", fs[i], 0);
        chk("rst_data", fd[i], 0);
        chk("rst_done", fdn[i], 0);
        chk("rst_err", err_w[i], 0);
        chk("rst_busy", busy_w[i], 0);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_t e;
        bit   have;
        have = rd[i] < expq.size();
        if (have) e = expq[rd[i]];
        if (act[i]) begin
          chk("ready_low", rdy[i], 0);
          if (fs[i] != 0) begin
            wid[i]++;
            chk("strobe_hold", fs[i], 32'(1) << e.idx);
            chk("data_stable", fd[i], e.data);
          end else begin
            chk("strobe_width", wid[i], scw[i]);
            chk("hold_data", fd[i], e.data);
            act[i] = 0;
            rd[i]++;
            pend[i] = cyc + 1;
          end
        end else if (fs[i] != 0) begin
          if (!have) begin
            chk("unexpected_strobe", fs[i], 0);
          end else begin
            chk("rise_cycle", cyc, e.e1 + 2);
            chk("strobe_onehot", fs[i], 32'(1) << e.idx);
            chk("strobe_data", fd[i], e.data);
            act[i] = 1;
            wid[i] = 1;
          end
        end else if (have && cyc == e.e1 + 1) begin
          chk("setup_data", fd[i], e.data);
          chk("setup_ready", rdy[i], 0);
        end else if (have && cyc > e.e1 + 2) begin
          chk("missing_strobe", 0, 1);
          rd[i]++;
        end
        if (pend[i] == cyc) begin
          dmod[i] = (dmod[i] + 1) % 256;
          chk("frames_done", fdn[i], dmod[i]);
          chk("idle_after", busy_w[i], 0);
          pend[i] = -1;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input bit clr,
                           output int e);
    int n = 0;
    @(negedge clk);
    while (!allrdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!allrdy) begin
      checks++; errors++;
      $display("FAIL ready_timeout: waited %0d cycles", n);
    end
    s_data = w; s_valid = 1; err_clr = clr;
    @(posedge clk);
    #1;
    e = cyc;
    s_valid = 0; err_clr = 0;
  endtask

  task automatic send_frame(input logic [7:0] idx,
                            input logic [7:0] sync,
                            input logic [15:0] up,
                            input logic [31:0] data,
                            input bit clr, input int gap);
    int  e;
    bit  good;
    good = (sync == 8'hFA) && (idx < 20);
    send_word({up, sync, idx}, clr, e);
    if (clr) err_m = 0;
    if (!good) err_m = 1;
    for (int i = 0; i < 3; i++) begin
      chk("err_flag", err_w[i], err_m);
      chk("busy_hdr", busy_w[i], good);
    end
    if (good) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          chk("wait_busy", busy_w[i], 1);
          chk("wait_nostrobe", fs[i], 0);
        end
      end
      send_word(data, 0, e);
      expq.push_back('{int'(idx), data, e});
      goods++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    err_m = 0;
    goods = 0;
  endtask

  task automatic drain();
    int n = 0;
    repeat (3) @(negedge clk);
    while (!allidle && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    resetn = 1;
    err_m = 0;
    // directed: basic frame, bad index, bad sync, stalled data
    send_frame(8'h05, 8'hFA, 16'h0000, 32'hDEADBEEF, 0, 0);
    send_frame(8'h14, 8'hFA, 16'h0000, 32'h0, 0, 0);
    send_frame(8'h13, 8'hFA, 16'h0000, 32'h12345678, 0, 0);
    send_frame(8'h20, 8'hFA, 16'h0000, 32'h0, 1, 0);
    @(negedge clk);
    err_clr = 1;
    @(posedge clk);
    #1;
    err_clr = 0;
    err_m = 0;
    for (int i = 0; i < 3; i++) chk("err_cleared", err_w[i], 0);
    send_frame(8'h00, 8'hFB, 16'h0000, 32'h0, 0, 0);
    send_frame(8'h00, 8'hFA, 16'hABCD, 32'hCAFEF00D, 0, 0);
    send_frame(8'h0B, 8'hFA, 16'h0000, 32'h55AA55AA, 0, 10);
    drain();
    // reset while the width-2 instance is strobing
    begin
      int n = 0;
      int e;
      send_word(32'h0000FA09, 0, e);
      send_word(32'h0F0F0F0F, 0, e);
      expq.push_back('{9, 32'h0F0F0F0F, e});
      @(negedge clk);
      while (fs[0] == 0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("strobe_before_reset", fs[0], 20'h00200);
      resetn = 0;
      @(negedge clk);
      resetn = 1;
      err_m = 0;
      goods = 0;
    end
    send_frame(8'h07, 8'hFA, 16'h0000, 32'h77777777, 0, 0);
    drain();
    // randomized stream until 256 good frames since reset
    do_reset();
    while (goods < 256) begin
      logic [7:0] idx;
      logic [7:0] sync;
      idx  = 8'($urandom_range(0, 23));
      sync = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFA;
      send_frame(idx, sync, 16'($urandom), $urandom,
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    end
    drain();
    for (int i = 0; i < 3; i++) begin
      chk("wrap_done", fdn[i], 32'(goods % 256));
      chk("all_consumed", rd[i], expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
